// File: rtl/mm_pkg.sv
// Shared constants and FSM encoding for the matrix-multiply job sequencer,
// its GEMM datapath and the surrounding environment.
package mm_pkg;

  localparam int MM_M           = 4;
  localparam int MM_N           = 3;
  localparam int MM_P           = 5;
  localparam int MM_DATA_WIDTH  = 16;
  localparam int MM_FRACT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } mm_state_t;

  // Width of the one element counter shared by every phase; at least one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int mx;
    mx = a;
    if (b > mx) mx = b;
    if (c > mx) mx = c;
    return (mx > 1) ? $clog2(mx) : 1;
  endfunction

endpackage

// File: rtl/matmul_job_sequencer.sv
// Sequences one GEMM job: serial load of A then B into flattened operand buses,
// one-cycle capture of the combinational product, then row-major result drain.
module matmul_job_sequencer
  import mm_pkg::*;
#(
  parameter int M           = MM_M,
  parameter int N           = MM_N,
  parameter int P           = MM_P,
  parameter int DATA_WIDTH  = MM_DATA_WIDTH,
  parameter int FRACT_WIDTH = MM_FRACT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  output logic [M*N*DATA_WIDTH-1:0]    mm_a,
  output logic [N*P*DATA_WIDTH-1:0]    mm_b,
  input  logic [M*P*DATA_WIDTH-1:0]    mm_y,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done
);

  localparam int NA    = M * N;
  localparam int NB    = N * P;
  localparam int NY    = M * P;
  localparam int DW    = DATA_WIDTH;
  localparam int CNT_W = cnt_width(NA, NB, NY);

  localparam logic [CNT_W-1:0] LAST_A = CNT_W'(NA - 1);
  localparam logic [CNT_W-1:0] LAST_B = CNT_W'(NB - 1);
  localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(NY - 1);

  // The Q-format split belongs to the datapath; elements pass through untouched.
  if (FRACT_WIDTH >= DATA_WIDTH) begin : g_fract_exceeds_width
  end

  mm_state_t              state_reg, state_next;
  logic [CNT_W-1:0]       counter_reg;
  logic [NA*DW-1:0]       mm_a_reg;
  logic [NB*DW-1:0]       mm_b_reg;
  logic [NY*DW-1:0]       y_reg;
  logic                   done_reg, done_next;

  logic                   cnt_clear, cnt_inc;
  logic                   a_we, b_we, y_we;
  logic [DW-1:0]          y_elem [NY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    a_we       = 1'b0;
    b_we       = 1'b0;
    y_we       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = LOAD_A;
          cnt_clear  = 1'b1;
        end
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_we = 1'b1;
          if (counter_reg == LAST_A) begin
            state_next = LOAD_B;
            cnt_clear  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          b_we = 1'b1;
          if (counter_reg == LAST_B) begin
            state_next = COMPUTE;
            cnt_clear  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      COMPUTE: begin
        // Operands have been stable for a full cycle; capture the product.
        y_we       = 1'b1;
        cnt_clear  = 1'b1;
        state_next = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (counter_reg == LAST_Y);
        if (out_ready) begin
          if (counter_reg == LAST_Y) begin
            state_next = IDLE;
            cnt_clear  = 1'b1;
            done_next  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_reg <= '0;
    end else if (cnt_clear) begin
      counter_reg <= '0;
    end else if (cnt_inc) begin
      counter_reg <= counter_reg + 1'b1;
    end
  end

  // Operand buses keep the previous job's values until each element is reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_a_reg <= '0;
      mm_b_reg <= '0;
      y_reg    <= '0;
    end else begin
      for (int i = 0; i < NA; i++) begin
        if (a_we && counter_reg == CNT_W'(i)) mm_a_reg[i*DW +: DW] <= in_data;
      end
      for (int i = 0; i < NB; i++) begin
        if (b_we && counter_reg == CNT_W'(i)) mm_b_reg[i*DW +: DW] <= in_data;
      end
      if (y_we) y_reg <= mm_y;
    end
  end

  for (genvar gi = 0; gi < NY; gi++) begin : g_y_view
    assign y_elem[gi] = y_reg[gi*DW +: DW];
  end

  always_comb begin
    out_data = '0;
    if (state_reg == DRAIN) begin
      for (int i = 0; i < NY; i++) begin
        if (counter_reg == CNT_W'(i)) out_data = y_elem[i];
      end
    end
  end

  assign mm_a = mm_a_reg;
  assign mm_b = mm_b_reg;
  assign busy = (state_reg != IDLE);
  assign done = done_reg;

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Self-checking bench for matmul_job_sequencer with a behavioural stand-in for
// the combinational GEMM datapath and a matrix-level reference model.
module tb_matmul_job_sequencer;
  import mm_pkg::*;

  localparam int M  = MM_M;
  localparam int N  = MM_N;
  localparam int P  = MM_P;
  localparam int DW = MM_DATA_WIDTH;
  localparam int FW = MM_FRACT_WIDTH;
  localparam int NA = M * N;
  localparam int NB = N * P;
  localparam int NY = M * P;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              out_ready = 1'b0;
  logic              in_ready, out_valid, out_last, busy, done;
  logic [DW-1:0]     out_data;
  logic [NA*DW-1:0]  mm_a;
  logic [NB*DW-1:0]  mm_b;
  logic [NY*DW-1:0]  mm_y;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] a_vec   [NA];
  logic [DW-1:0] b_vec   [NB];
  logic [DW-1:0] exp_vec [NY];

  typedef struct {
    int              id;
    logic [DW-1:0]   a_even;
    logic [DW-1:0]   a_odd;
    logic [DW-1:0]   b_all;
    bit              gaps;
    bit              stall;
    logic [DW-1:0]   row0, row1, row2, row3;
  } vec_t;

  vec_t tbl [4];

  always #5 clk = ~clk;

  matmul_job_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mm_a(mm_a), .mm_b(mm_b), .mm_y(mm_y),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  // Stand-in for the combinational matrix_multiplier fed from the DUT buses.
  function automatic logic [NY*DW-1:0] gemm_stub(input logic [NA*DW-1:0] a,
                                                 input logic [NB*DW-1:0] b);
    logic [NY*DW-1:0] y;
    longint acc;
    y = '0;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < P; c++) begin
        acc = 0;
        for (int k = 0; k < N; k++) begin
          acc += longint'($signed(a[(r*N+k)*DW +: DW])) * longint'($signed(b[(k*P+c)*DW +: DW]));
        end
        y[(r*P+c)*DW +: DW] = DW'(acc >>> FW);
      end
    end
    return y;
  endfunction

  assign mm_y = gemm_stub(mm_a, mm_b);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Expected product straight from the stimulus matrices.
  task automatic ref_model();
    longint acc;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < P; c++) begin
        acc = 0;
        for (int k = 0; k < N; k++) acc += $signed(a_vec[r*N+k]) * $signed(b_vec[k*P+c]);
        exp_vec[r*P+c] = DW'(acc >>> FW);
      end
    end
  endtask

  task automatic fill_from_table(input int i);
    for (int k = 0; k < NA; k++) a_vec[k] = (k % 2 == 1) ? tbl[i].a_odd : tbl[i].a_even;
    for (int k = 0; k < NB; k++) b_vec[k] = tbl[i].b_all;
    for (int c = 0; c < P; c++) begin
      exp_vec[0*P+c] = tbl[i].row0;
      exp_vec[1*P+c] = tbl[i].row1;
      exp_vec[2*P+c] = tbl[i].row2;
      exp_vec[3*P+c] = tbl[i].row3;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"},  in_ready,  0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_busy"},      busy,      0);
    chk({tag, "_done"},      done,      0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_mm_a_zero"}, 64'(mm_a == '0), 1);
    chk({tag, "_mm_b_zero"}, 64'(mm_b == '0), 1);
  endtask

  task automatic send_operands(input int n_elems, input bit gaps, input bit start_noise);
    int  idx;
    int  guard;
    bit  hs;
    idx = 0;
    guard = 0;
    while (idx < n_elems && guard < 2000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = (idx < NA) ? a_vec[idx] : b_vec[idx-NA];
      start    = start_noise && (idx == 5);
      hs       = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (idx != n_elems) chk("load_timeout", 64'(idx), 64'(n_elems));
  endtask

  task automatic drain(input bit stall, input bit start_noise, input bit chain_out);
    int            cnt;
    int            guard;
    bit            held_v;
    logic [DW-1:0] held;
    // Right after the last B handshake the job is computing, not yet draining.
    chk("compute_no_valid", out_valid, 0);
    chk("compute_busy", busy, 1);
    chk("compute_no_ready", in_ready, 0);
    guard = 0;
    while (!out_valid && guard < 3) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("first_valid_latency", out_valid, 1);
    cnt = 0;
    guard = 0;
    held_v = 1'b0;
    held = '0;
    out_ready = 1'b0;
    while (cnt < NY && guard < 1000) begin
      out_ready = stall ? ~out_ready : 1'b1;
      start     = start_noise && (cnt == 7);
      if (held_v) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", out_data, held);
      end
      if (out_valid && out_ready) begin
        chk("y_data", out_data, exp_vec[cnt]);
        chk("y_last", out_last, 64'(cnt == NY - 1));
        $display("result %0d data=%h last=%b", cnt, out_data, out_last);
        cnt++;
        held_v = 1'b0;
      end else if (out_valid) begin
        held_v = 1'b1;
        held   = out_data;
      end
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (cnt != NY) chk("drain_timeout", 64'(cnt), 64'(NY));
    chk("done_pulse", done, 1);
    chk("idle_busy", busy, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 0);
    if (chain_out) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 64'(chain_out));
  endtask

  task automatic run_job(input bit gaps, input bit stall, input bit start_noise,
                         input bit skip_start, input bit chain_out);
    if (!skip_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("busy_after_start", busy, 1);
    send_operands(NA + NB, gaps, start_noise);
    drain(stall, start_noise, chain_out);
    $display("job finished gaps=%0d stall=%0d noise=%0d", gaps, stall, start_noise);
  endtask

  initial begin
    tbl[0] = '{1, 16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 16'h0300, 16'h0300, 16'h0300, 16'h0300};
    tbl[1] = '{2, 16'h0300, 16'hFE00, 16'h0100, 1'b0, 1'b0, 16'h0400, 16'hFF00, 16'h0400, 16'hFF00};
    tbl[2] = '{3, 16'h0100, 16'h0100, 16'h0100, 1'b1, 1'b1, 16'h0300, 16'h0300, 16'h0300, 16'h0300};
    tbl[3] = '{6, 16'h0002, 16'h0002, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      fill_from_table(i);
      $display("table case %0d", tbl[i].id);
      run_job(tbl[i].gaps, tbl[i].stall, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset partway through the B load.
    fill_from_table(0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_operands(NA + 7, 1'b0, 1'b0);
    chk("mid_load_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stray start pulses are ignored; a start on the done cycle launches the next job.
    fill_from_table(0);
    run_job(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    fill_from_table(1);
    run_job(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("no_extra_job_valid", out_valid, 0);
      chk("no_extra_job_busy", busy, 0);
    end

    // Random operands against the reference model.
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < NA; k++) a_vec[k] = DW'($urandom);
      for (int k = 0; k < NB; k++) b_vec[k] = DW'($urandom_range(0, 16'h0400)) - 16'h0200;
      ref_model();
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
